// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state type for the UART transmit feeder
package uart_pkg;
    localparam int BYTE_W    = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_AW    = 4;
    localparam int DEF_TMO_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_DONE
    } tx_state_e;
endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - circular byte FIFO with level count, sticky overflow and flush
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [BYTE_W-1:0] wr_data_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic              flush_i,
    input  logic              clr_overflow_i,
    output logic [BYTE_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       level_o,
    output logic              overflow_o
);
    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              full_q, empty_q;
    logic              overflow_q, overflow_d;
    logic              wr_ok, rd_ok;

    // Acceptance is judged on the registered (pre-edge) full/empty flags.
    assign wr_ok = wr_en_i && !full_q && !flush_i;
    assign rd_ok = rd_en_i && !empty_q && !flush_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(wr_ok);
        rd_ptr_d   = rd_ptr_q + AW'(rd_ok);
        level_d    = level_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        overflow_d = overflow_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
        if (clr_overflow_i) begin
            overflow_d = 1'b0;
        end
        if (wr_en_i && full_q && !flush_i) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= (level_d == (AW+1)'(DEPTH));
            empty_q    <= (level_d == '0);
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers host bytes and sequences transmit/tx_busy handshakes to a UART
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int TMO_W = DEF_TMO_W
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [BYTE_W-1:0] wr_data_i,
    input  logic              wr_en_i,
    input  logic              flush_i,
    input  logic              clr_overflow_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       level_o,
    output logic              overflow_o,
    output logic              tx_timeout_o,
    output logic [BYTE_W-1:0] data_in_o,
    output logic              transmit_o,
    input  logic              tx_busy_i
);
    tx_state_e         state_q;
    logic [TMO_W-1:0]  timer_q;
    logic [TMO_W-1:0]  timer_inc;
    logic [BYTE_W-1:0] data_in_q;
    logic              transmit_q;
    logic              tx_timeout_q;
    logic [BYTE_W-1:0] head_byte;
    logic              fifo_empty;
    logic              pop;

    assign pop       = (state_q == ST_IDLE) && !fifo_empty && !tx_busy_i && !flush_i;
    assign timer_inc = timer_q + 1'b1;

    uart_byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .wr_data_i      (wr_data_i),
        .wr_en_i        (wr_en_i),
        .rd_en_i        (pop),
        .flush_i        (flush_i),
        .clr_overflow_i (clr_overflow_i),
        .rd_data_o      (head_byte),
        .full_o         (full_o),
        .empty_o        (fifo_empty),
        .level_o        (level_o),
        .overflow_o     (overflow_o)
    );

    // transmit stays up in LOAD until the UART, sampling on its baud tick, reports busy.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            data_in_q    <= '0;
            transmit_q   <= 1'b0;
            tx_timeout_q <= 1'b0;
        end else begin
            tx_timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        data_in_q  <= head_byte;
                        transmit_q <= 1'b1;
                        timer_q    <= '0;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (tx_busy_i) begin
                        transmit_q <= 1'b0;
                        timer_q    <= '0;
                        state_q    <= ST_WAIT_DONE;
                    end else if (&timer_inc) begin
                        transmit_q   <= 1'b0;
                        tx_timeout_q <= 1'b1;
                        timer_q      <= '0;
                        state_q      <= ST_IDLE;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign empty_o      = fifo_empty;
    assign data_in_o    = data_in_q;
    assign transmit_o   = transmit_q;
    assign tx_timeout_o = tx_timeout_q;
endmodule
